// File: rtl/sdarb_pkg.sv
// Shared definitions for the SDRAM bus arbiter.
//   state_t     : arbiter FSM encoding (ST_IDLE / ST_OWN)
//   onehot2idx  : one-hot grant vector to binary master index
//   prio_pick   : rotating priority pick, returns a one-hot vector
// Vectors are sized for the largest supported master count (8); callers
// zero-extend narrower vectors.
package sdarb_pkg;

    localparam int MAX_MASTERS = 8;
    localparam int PTR_W       = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    function automatic logic [PTR_W-1:0] onehot2idx(input logic [MAX_MASTERS-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < MAX_MASTERS; k++) begin
            if (oh[k]) idx = idx | PTR_W'(k);
        end
        return idx;
    endfunction

    // First asserted request at or after ptr, wrapping at n-1 back to 0.
    function automatic logic [MAX_MASTERS-1:0] prio_pick(input logic [MAX_MASTERS-1:0] req,
                                                         input logic [PTR_W-1:0]       ptr,
                                                         input int                     n);
        logic [MAX_MASTERS-1:0] res;
        logic                   found;
        int                     idx;
        res   = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_MASTERS; k++) begin
            if (k < n) begin
                idx = (int'(ptr) + k) % n;
                if (!found && req[idx[PTR_W-1:0]]) begin
                    res[idx[PTR_W-1:0]] = 1'b1;
                    found               = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sdarb_prio_pick.sv
// Combinational rotating priority encoder, N masters wide.
// Ports:
//   req  in  N      request vector
//   ptr  in  PTR_W  index that has highest priority this cycle
//   pick out N      one-hot winner, all-zero when req is all-zero
module sdarb_prio_pick
    import sdarb_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     pick
);

    logic [MAX_MASTERS-1:0] req_ext;
    logic [MAX_MASTERS-1:0] pick_ext;
    // Bits above N are always zero; folded here only so nothing dangles.
    logic                   unused_pick_bits;

    always_comb begin
        req_ext          = '0;
        req_ext[N-1:0]   = req;
        pick_ext         = prio_pick(req_ext, ptr, N);
        pick             = pick_ext[N-1:0];
        unused_pick_bits = ^pick_ext;
    end

endmodule

// File: rtl/sdram_bus_arbiter.sv
// N-master arbiter in front of the sdramburst controller (SDRAM clock domain).
// Grants one master for a whole burst, muxes its request fields onto the
// controller port and routes the data_bursting strobe back to it.
// Optional build macro: SDARB_STARVE_GUARD_EN (per-master wait counters that
// force the owner off the bus once a waiting master reaches STARVE_LIMIT).
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   m_rw_req/m_rw                   per-master request level / write flag
//   m_address/m_write_data/m_burst_len  packed per-master fields
//   m_bursting                      sd_bursting gated by grant
//   m_read_data                     sd_read_data broadcast
//   grant                           one-hot owner, zero when idle
//   sd_rw_req/sd_rw/sd_address/sd_write_data/sd_burst_len  to sdramburst
//   sd_bursting/sd_read_data        from sdramburst
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no owner; any request is arbitrated on the next edge
// ST_OWN  | grant held; released when bursting=0 and owner stops asking
module sdram_bus_arbiter
    import sdarb_pkg::*;
#(
    parameter int                     NUM_MASTERS  = 3,
    parameter int                     ADDR_W       = 32,
    parameter int                     DATA_W       = 16,
    parameter int                     BLEN_W       = 1,
    parameter int                     RR_MODE      = 0,
    parameter logic [NUM_MASTERS-1:0] RD_ONLY_MASK = 'b001,
    parameter int                     STARVE_LIMIT = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_MASTERS-1:0]        m_rw_req,
    input  logic [NUM_MASTERS-1:0]        m_rw,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_write_data,
    input  logic [NUM_MASTERS*BLEN_W-1:0] m_burst_len,
    output logic [NUM_MASTERS-1:0]        m_bursting,
    output logic [DATA_W-1:0]             m_read_data,
    output logic [NUM_MASTERS-1:0]        grant,
    output logic                          sd_rw_req,
    output logic                          sd_rw,
    output logic [ADDR_W-1:0]             sd_address,
    output logic [DATA_W-1:0]             sd_write_data,
    output logic [BLEN_W-1:0]             sd_burst_len,
    input  logic                          sd_bursting,
    input  logic [DATA_W-1:0]             sd_read_data
);

    state_t                   state_q, state_d;
    logic [NUM_MASTERS-1:0]   grant_q, grant_d;
    logic                     req_q, req_d;
    logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;

    logic [PTR_W-1:0]         pick_ptr;
    logic [NUM_MASTERS-1:0]   policy_pick;
    logic [NUM_MASTERS-1:0]   winner;
    logic [MAX_MASTERS-1:0]   winner_ext;
    logic [PTR_W-1:0]         win_idx;
    logic                     owner_req;
    logic                     force_release;

    // Fixed priority is round-robin with the pointer pinned to master 0.
    assign pick_ptr = (RR_MODE != 0) ? rr_ptr_q : '0;

    sdarb_prio_pick #(.N(NUM_MASTERS)) u_policy_pick (
        .req  (m_rw_req),
        .ptr  (pick_ptr),
        .pick (policy_pick)
    );

`ifdef SDARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0]       wait_cnt [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] starved;
    logic [NUM_MASTERS-1:0] starve_pick;

    // A saturated counter only matters while its master is still asking.
    always_comb begin
        starved = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            starved[i] = m_rw_req[i] && (wait_cnt[i] >= CNT_W'(STARVE_LIMIT));
        end
    end

    sdarb_prio_pick #(.N(NUM_MASTERS)) u_starve_pick (
        .req  (starved),
        .ptr  (PTR_W'(0)),
        .pick (starve_pick)
    );

    assign force_release = |starved;
    assign winner        = force_release ? starve_pick : policy_pick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_MASTERS; i++) wait_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (grant_d[i] && !grant_q[i]) begin
                    wait_cnt[i] <= '0;
                end else if (m_rw_req[i] && !grant_q[i] &&
                             wait_cnt[i] != CNT_W'(STARVE_LIMIT)) begin
                    wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
                end
            end
        end
    end
`else
    // Guard disabled: the limit has no effect in this build.
    localparam int unused_starve_limit = STARVE_LIMIT;

    assign force_release = 1'b0;
    assign winner        = policy_pick;
`endif

    always_comb begin
        winner_ext                  = '0;
        winner_ext[NUM_MASTERS-1:0] = winner;
        win_idx                     = onehot2idx(winner_ext);
    end

    assign owner_req = |(m_rw_req & grant_q);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        req_d    = req_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (|m_rw_req) begin
                    grant_d  = winner;
                    req_d    = 1'b1;
                    state_d  = ST_OWN;
                    rr_ptr_d = (win_idx == PTR_W'(NUM_MASTERS - 1)) ? '0 : win_idx + PTR_W'(1);
                end
            end
            ST_OWN: begin
                req_d = owner_req;
                if (!sd_bursting && (!owner_req || force_release)) begin
                    grant_d = '0;
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            req_q    <= 1'b0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            req_q    <= req_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // AND-OR mux off the registered one-hot grant; zero when idle.
    always_comb begin
        sd_address    = '0;
        sd_write_data = '0;
        sd_burst_len  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) begin
                sd_address    = sd_address    | m_address[i*ADDR_W +: ADDR_W];
                sd_write_data = sd_write_data | m_write_data[i*DATA_W +: DATA_W];
                sd_burst_len  = sd_burst_len  | m_burst_len[i*BLEN_W +: BLEN_W];
            end
        end
    end

    assign sd_rw       = |(grant_q & m_rw & ~RD_ONLY_MASK);
    assign m_bursting  = grant_q & {NUM_MASTERS{sd_bursting}};
    assign m_read_data = sd_read_data;
    assign grant       = grant_q;
    assign sd_rw_req   = req_q;

endmodule

// File: tb/tb_sdram_bus_arbiter.sv
module tb_sdram_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [2:0]  rw;
    logic [95:0] addr;
    logic [47:0] wdata;
    logic [2:0]  blen;
    logic        sd_bursting;
    logic [15:0] sd_read_data;

    logic [2:0]  f_m_bursting, f_grant, r_m_bursting, r_grant;
    logic [15:0] f_m_read_data, f_sd_write_data, r_m_read_data, r_sd_write_data;
    logic        f_sd_rw_req, f_sd_rw, r_sd_rw_req, r_sd_rw;
    logic [31:0] f_sd_address, r_sd_address;
    logic        f_sd_burst_len, r_sd_burst_len;

    int          n_vec = 0;
    int          n_err = 0;
    logic [2:0]  exp_q[$];

    always #5 clk = ~clk;

    sdram_bus_arbiter #(.NUM_MASTERS(3), .RR_MODE(0), .RD_ONLY_MASK(3'b001), .STARVE_LIMIT(8)) u_fix (
        .clk(clk), .reset(rst_n), .m_rw_req(req), .m_rw(rw), .m_address(addr),
        .m_write_data(wdata), .m_burst_len(blen), .m_bursting(f_m_bursting),
        .m_read_data(f_m_read_data), .grant(f_grant), .sd_rw_req(f_sd_rw_req),
        .sd_rw(f_sd_rw), .sd_address(f_sd_address), .sd_write_data(f_sd_write_data),
        .sd_burst_len(f_sd_burst_len), .sd_bursting(sd_bursting), .sd_read_data(sd_read_data)
    );

    sdram_bus_arbiter #(.NUM_MASTERS(3), .RR_MODE(1), .RD_ONLY_MASK(3'b001), .STARVE_LIMIT(8)) u_rr (
        .clk(clk), .reset(rst_n), .m_rw_req(req), .m_rw(rw), .m_address(addr),
        .m_write_data(wdata), .m_burst_len(blen), .m_bursting(r_m_bursting),
        .m_read_data(r_m_read_data), .grant(r_grant), .sd_rw_req(r_sd_rw_req),
        .sd_rw(r_sd_rw), .sd_address(r_sd_address), .sd_write_data(r_sd_write_data),
        .sd_burst_len(r_sd_burst_len), .sd_bursting(sd_bursting), .sd_read_data(sd_read_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        req         = '0;
        rw          = '0;
        sd_bursting = 1'b0;
        exp_q.delete();
        #7;
        rst_n = 1'b1;
        tick();
    endtask

    // Wait (bounded) for a grant, compare it with the next scoreboard entry,
    // then run a short burst with the owner dropping its request.
    task automatic serve(input bit use_rr, input bit reraise);
        logic [2:0] g;
        logic [2:0] e;
        int         cyc;
        cyc = 0;
        g   = use_rr ? r_grant : f_grant;
        while (g == 3'b000 && cyc < 20) begin
            tick();
            cyc++;
            g = use_rr ? r_grant : f_grant;
        end
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = 3'b111;
        chk("grant_order", g, e);
        chk("sd_rw_req_on_grant", use_rr ? r_sd_rw_req : f_sd_rw_req, 1);
        req         = req & ~g;
        sd_bursting = 1'b1;
        tick();
        chk("burst_strobe", use_rr ? r_m_bursting : f_m_bursting, g);
        tick();
        sd_bursting = 1'b0;
        tick();
        chk("release", use_rr ? r_grant : f_grant, 0);
        if (reraise) req = req | g;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lost;
        bit   got, saw_idle;
        addr         = {32'hC000_0300, 32'hB000_0200, 32'hA000_0100};
        wdata        = {16'h3333, 16'h2222, 16'h1111};
        blen         = 3'b010;
        sd_read_data = 16'h5A5A;

        // Reset state and single request
        do_reset();
        chk("rst_grant", f_grant, 0);
        chk("rst_sd_rw_req", f_sd_rw_req, 0);
        chk("rst_sd_address", f_sd_address, 0);
        chk("rst_sd_write_data", f_sd_write_data, 0);
        chk("rst_rr_grant", r_grant, 0);
        req = 3'b010;
        rw  = 3'b010;
        #1;
        chk("no_comb_grant", f_grant, 0);
        tick();
        chk("single_grant", f_grant, 3'b010);
        chk("single_sd_rw_req", f_sd_rw_req, 1);
        chk("single_address", f_sd_address, 32'hB000_0200);
        chk("single_wdata", f_sd_write_data, 16'h2222);
        chk("single_blen", f_sd_burst_len, 1);
        chk("single_sd_rw", f_sd_rw, 1);
        chk("read_bcast", f_m_read_data, 16'h5A5A);
        req         = 3'b000;
        sd_bursting = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("burst_hold", f_m_bursting, 3'b010);
        end
        chk("req_follows_owner", f_sd_rw_req, 0);
        sd_bursting = 1'b0;
        tick();
        chk("single_release", f_grant, 0);
        chk("idle_address", f_sd_address, 0);

        // Fixed priority
        do_reset();
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b100);
        req = 3'b110;
        serve(1'b0, 1'b0);
        serve(1'b0, 1'b0);
        chk("fixed_sb_empty", exp_q.size(), 0);

        // Round-robin
        do_reset();
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b001);
        req = 3'b111;
        for (int k = 0; k < 4; k++) serve(1'b1, 1'b1);
        chk("rr_sb_empty", exp_q.size(), 0);
        req = 3'b000;
        tick();

        // Read-only mask
        do_reset();
        req = 3'b001;
        rw  = 3'b001;
        tick();
        chk("ro_grant", f_grant, 3'b001);
        chk("ro_sd_rw", f_sd_rw, 0);
        req = 3'b000;
        tick();
        chk("ro_release", f_grant, 0);
        req = 3'b010;
        rw  = 3'b010;
        tick();
        chk("rw_grant", f_grant, 3'b010);
        chk("rw_sd_rw", f_sd_rw, 1);
        req = 3'b000;
        tick();

        // Reset mid-burst
        do_reset();
        req = 3'b001;
        tick();
        sd_bursting = 1'b1;
        tick();
        chk("pre_reset_grant", f_grant, 3'b001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_grant", f_grant, 0);
        chk("async_rst_req", f_sd_rw_req, 0);
        chk("async_rst_bursting", f_m_bursting, 0);
        req         = 3'b100;
        sd_bursting = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
        chk("post_reset_grant", f_grant, 3'b100);
        req = 3'b000;
        tick();

        // Continuously requesting owner versus a waiting master
        do_reset();
        req = 3'b101;
        tick();
        chk("hog_grant", f_grant, 3'b001);
        lost     = 0;
        got      = 1'b0;
        saw_idle = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (!got) begin
                sd_bursting = (k % 4) != 3;
                tick();
                if (f_grant != 3'b001) lost++;
                if (f_grant == 3'b000) saw_idle = 1'b1;
                if (f_grant == 3'b100) got = 1'b1;
            end
        end
`ifdef SDARB_STARVE_GUARD_EN
        chk("starve_forced_grant", got, 1);
        chk("starve_idle_gap", saw_idle, 1);
`else
        chk("owner_holds", lost, 0);
`endif
        req         = 3'b000;
        sd_bursting = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
